// File: rtl/bufgmux_ctrl_pkg.sv
// Shared types and constants for the global clock mux select controller.
package bufgmux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_e;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/bufgmux_sel_ctrl.sv
// Select-line controller for the global clock mux: handshaked switch requests,
// dead-clock rejection, automatic failover, and settle/dwell hold windows.
module bufgmux_sel_ctrl
  import bufgmux_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES  = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic alive0,
  input  logic alive1,
  input  logic failover_en,
  output logic selection,
  output logic busy,
  output logic switch_done,
  output logic req_err,
  output logic failover
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic             selection_q, selection_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switch_done_q, switch_done_d;
  logic             req_err_q, req_err_d;
  logic             failover_q, failover_d;

  logic alive_cur, alive_oth, fo_cond, accept, req_alive;

  assign alive_cur = selection_q ? alive1 : alive0;
  assign alive_oth = selection_q ? alive0 : alive1;
  assign fo_cond   = failover_en && !alive_cur && alive_oth;
  assign req_alive = req_sel ? alive1 : alive0;
  assign req_ready = !areset && (state_q == ST_IDLE) && !fo_cond;
  assign accept    = req_valid && req_ready;

  // Next-state, selection and counter; failover outranks any user request.
  always_comb begin
    state_d       = state_q;
    selection_d   = selection_q;
    cnt_d         = cnt_q;
    switch_done_d = 1'b0;
    req_err_d     = 1'b0;
    failover_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fo_cond) begin
          selection_d = !selection_q;
          failover_d  = 1'b1;
          cnt_d       = SETTLE_LOAD;
          state_d     = ST_SETTLE;
        end else if (accept) begin
          if (req_sel == selection_q) begin
            switch_done_d = 1'b1;
          end else if (!req_alive) begin
            req_err_d = 1'b1;
          end else begin
            selection_d = req_sel;
            cnt_d       = SETTLE_LOAD;
            state_d     = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(0)) begin
          switch_done_d = 1'b1;
          cnt_d         = DWELL_LOAD;
          state_d       = ST_DWELL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DWELL: begin
        if (fo_cond) begin
          selection_d = !selection_q;
          failover_d  = 1'b1;
          cnt_d       = SETTLE_LOAD;
          state_d     = ST_SETTLE;
        end else if (cnt_q == CNT_W'(0)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      selection_q   <= SEL_IN0;
      cnt_q         <= CNT_W'(0);
      switch_done_q <= 1'b0;
      req_err_q     <= 1'b0;
      failover_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      selection_q   <= selection_d;
      cnt_q         <= cnt_d;
      switch_done_q <= switch_done_d;
      req_err_q     <= req_err_d;
      failover_q    <= failover_d;
    end
  end

  assign selection   = selection_q;
  assign busy        = (state_q != ST_IDLE);
  assign switch_done = switch_done_q;
  assign req_err     = req_err_q;
  assign failover    = failover_q;

endmodule

// File: tb/tb_bufgmux_sel_ctrl.sv
// Directed bench for bufgmux_sel_ctrl; a timestamp-based model predicts outputs every cycle.
module tb_bufgmux_sel_ctrl;

  localparam int S = 4;
  localparam int D = 8;

  logic aclk = 1'b0;
  logic rst, rv, rs, a0, a1, fen;
  logic req_ready, selection, busy, switch_done, req_err, failover;

  bufgmux_sel_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D)) dut (
    .aclk(aclk), .areset(rst), .req_valid(rv), .req_sel(rs), .req_ready(req_ready),
    .alive0(a0), .alive1(a1), .failover_en(fen), .selection(selection), .busy(busy),
    .switch_done(switch_done), .req_err(req_err), .failover(failover)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model: current selection plus the cycle numbers at which the settle ends
  // (switch_done visible) and at which the block is free again.
  bit m_sel  = 1'b0;
  int m_done = -1;
  int m_free = 0;
  bit p_noop, p_err, p_fo;
  bit last_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit alv(input bit s);
    return s ? bit'(a1) : bit'(a0);
  endfunction

  task automatic tick();
    int t;
    bit idle, settle, fo, er;
    #1;
    t      = cyc;
    idle   = (t >= m_free);
    settle = !idle && (t < m_done);
    fo     = fen && !alv(m_sel) && alv(!m_sel);
    er     = !rst && idle && !fo;
    chk("req_ready", req_ready, er);
    last_hs = rv && er;
    p_noop = 1'b0; p_err = 1'b0; p_fo = 1'b0;
    if (rst) begin
      m_sel = 1'b0; m_done = -1; m_free = 0;
    end else if (!settle && fo) begin
      m_sel = !m_sel; p_fo = 1'b1;
      m_done = t + 1 + S; m_free = t + 1 + S + D;
    end else if (idle && rv) begin
      if (rs == m_sel) p_noop = 1'b1;
      else if (!alv(rs)) p_err = 1'b1;
      else begin
        m_sel = rs; m_done = t + 1 + S; m_free = t + 1 + S + D;
      end
    end
    @(posedge aclk);
    cyc++;
    #1;
    chk("selection", selection, m_sel);
    chk("busy", busy, cyc < m_free);
    chk("switch_done", switch_done, p_noop || (cyc == m_done));
    chk("req_err", req_err, p_err);
    chk("failover", failover, p_fo);
    @(negedge aclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; rv = 1'b0; rs = 1'b0; a0 = 1'b1; a1 = 1'b1; fen = 1'b0;
    @(negedge aclk);
    tick(); tick();
    chk("lit_reset_sel", selection, 1'b0);
    chk("lit_reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Normal switch to input 1, handshake at T; a stray valid during settle is ignored.
    rv = 1'b1; rs = 1'b1;
    tick();
    chk("lit_hs_T", last_hs, 1'b1);
    rv = 1'b0;
    chk("lit_sel_T+1", selection, 1'b1);
    rv = 1'b1; rs = 1'b0; tick(); rv = 1'b0;
    repeat (2) tick();
    tick();
    chk("lit_done_T+5", switch_done, 1'b1);
    repeat (7) tick();
    #1 chk("lit_ready_T+12", req_ready, 1'b0);
    tick();
    #1 chk("lit_ready_T+13", req_ready, 1'b1);

    // Back to 0, then request onto a dead clock is rejected.
    rv = 1'b1; rs = 1'b0; tick(); rv = 1'b0;
    repeat (12) tick();
    a1 = 1'b0; rv = 1'b1; rs = 1'b1;
    tick();
    rv = 1'b0;
    chk("lit_err_pulse", req_err, 1'b1);
    chk("lit_err_sel", selection, 1'b0);
    chk("lit_err_busy", busy, 1'b0);
    tick();
    a1 = 1'b1;

    // No-op request to the current input.
    rv = 1'b1; rs = 1'b0; tick(); rv = 1'b0;
    chk("lit_noop_done", switch_done, 1'b1);
    chk("lit_noop_sel", selection, 1'b0);
    tick();

    // Failover out of DWELL.
    rv = 1'b1; rs = 1'b1; tick(); rv = 1'b0;
    repeat (5) tick();
    fen = 1'b1; a1 = 1'b0;
    tick();
    chk("lit_fo_sel", selection, 1'b0);
    chk("lit_fo_pulse", failover, 1'b1);
    repeat (3) tick();
    tick();
    chk("lit_fo_done", switch_done, 1'b1);
    repeat (9) tick();

    // Failover and a user request in the same IDLE cycle: failover wins.
    a0 = 1'b0; a1 = 1'b1; rv = 1'b1; rs = 1'b1;
    #1 chk("lit_fo_ready_low", req_ready, 1'b0);
    tick();
    chk("lit_fo2_pulse", failover, 1'b1);
    chk("lit_fo2_sel", selection, 1'b1);
    n = 0;
    last_hs = 1'b0;
    while (!last_hs && n < 40) begin
      tick();
      n++;
    end
    chk("lit_req_after_dwell", n, 13);
    rv = 1'b0;
    tick();

    // Both clocks dead: nothing moves.
    a0 = 1'b0; a1 = 1'b0;
    repeat (3) tick();
    a0 = 1'b1; a1 = 1'b1; fen = 1'b0;

    // Reset during SETTLE with selection = 1.
    rv = 1'b1; rs = 1'b0; tick(); rv = 1'b0;
    repeat (12) tick();
    rv = 1'b1; rs = 1'b1; tick(); rv = 1'b0;
    tick();
    chk("lit_pre_rst_sel", selection, 1'b1);
    rst = 1'b1;
    tick();
    chk("lit_rst_sel", selection, 1'b0);
    chk("lit_rst_busy", busy, 1'b0);
    chk("lit_rst_pulses", {switch_done, req_err, failover}, 3'b000);
    rst = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
